cdp1802_dma_ctrl: RTL and testbench
===================================

# cdp1802_dma_ctrl

CPU-side DMA-out and interrupt responder for the CDP1861 Pixie path. It services the Pixie `DMAO` and `INT` requests by stealing CDP1802 machine cycles. In each stolen S2 (DMA) cycle it reads memory at R0, drives the byte and `SC = 2'b10` to the Pixie front end, then post-increments R0. It sits between the CPU core's bus sequencer, system memory and the Pixie `data_in`/`SC` inputs, in the same `clk`/`clk_enable` domain as the Pixie front end.

## Interface
Parameters:
- `CYCLE_LEN`, default 8: `clk_enable` ticks per machine cycle; legal range 4..16.
- `RD_LAT`, default 1: ticks from `mem_rd` to valid `mem_data`; legal range 1..`CYCLE_LEN`-3.

Ports:
- `clk`  in  1  CPU bus clock.
- `reset`  in  1  asynchronous, active-low.
- `clk_enable`  in  1  tick qualifier. All state advances only when this is high.
- `cpu_sc`  in  2  CPU's own state code, passed through while the CPU owns the bus.
- `cpu_cycle_end`  in  1  one-tick pulse on the last tick of each CPU S1 cycle (instruction boundary).
- `dma_req`  in  1  Pixie `DMAO`, level.
- `int_req`  in  1  Pixie `INT`, level.
- `ie_set`  in  1  one-tick pulse that sets IE (RET/DIS decode).
- `r0_load`  in  1  loads R0 from `r0_in`.
- `r0_in`  in  16  new R0 value.
- `mem_data`  in  8  memory read data.
- `SC`  out  2  state code to the Pixie and the system.
- `data_out`  out  8  DMA byte to Pixie `data_in`.
- `mem_addr`  out  16  memory address during DMA.
- `mem_rd`  out  1  one-tick memory read strobe.
- `cpu_hold`  out  1  stalls the CPU sequencer while high.
- `int_ack`  out  1  one-tick pulse on interrupt entry.
- `r0`  out  16  current R0.
- `ie`  out  1  interrupt enable.

## Operation
FSM states are `RUN`, `DMA` and `INT`.

- **RUN**
  - `SC = cpu_sc` and `cpu_hold = 0`.
  - On a tick with `cpu_cycle_end`:
    - If `dma_req` is high, go to `DMA`.
    - Else if `int_req & ie`, go to `INT`.
    - Else stay in `RUN`.
  - DMA has priority over INT.
- **DMA**
  - `SC = 2'b10` and `cpu_hold = 1` for exactly `CYCLE_LEN` ticks, counted by tick counter `t` = 0..`CYCLE_LEN`-1.
  - At `t = 0`: `mem_rd = 1` and `mem_addr = r0`.
  - At `t = RD_LAT`: `mem_data` is captured into `data_out`. `data_out` holds that value until the next capture.
  - At `t = CYCLE_LEN-1`:
    - `r0 <= r0 + 1`, modulo 2^16 (FFFF wraps to 0000).
    - Resample `dma_req`. If high, start another `DMA` cycle with `t = 0`, which allows back-to-back bursts (the Pixie issues 8 per line).
    - Else if `int_req & ie`, go to `INT`.
    - Else go to `RUN`.
- **INT**
  - `SC = 2'b11` and `cpu_hold = 1` for `CYCLE_LEN` ticks.
  - `int_ack` pulses and `ie <= 0` at `t = 0`.
  - At `t = CYCLE_LEN-1`, resample `dma_req`: if high go to `DMA`, else go to `RUN`.
- **R0 loads**
  - `r0_load` is honored only in `RUN`. It is ignored in `DMA` and `INT`, because the CPU is held.
  - `ie_set` is honored in `RUN` only.
- `mem_addr` is 0 whenever `mem_rd = 0`.

## Timing
- **Reset values:**
  - `SC = 2'b00`, `data_out = 8'h00`, `mem_addr = 0`, `mem_rd = 0`.
  - `cpu_hold = 0`, `int_ack = 0`, `r0 = 16'h0000`, `ie = 1`.
  - The FSM is in `RUN` with `t = 0`.
- Reset asserted mid-DMA aborts the cycle immediately. No R0 increment occurs.
- **Outputs:** `SC`, `cpu_hold` and `data_out` are registered. `mem_rd` and `mem_addr` are registered, asserted on the tick entering `t = 0`.
- **Latency:** the first `SC = 10` tick follows the `cpu_cycle_end` tick by exactly one tick.
- **`clk_enable` low:** all registers hold, including single-tick pulses. A pulse therefore stays high across stalled clocks but spans exactly one enabled tick.
- **Request levels:** `dma_req` and `int_req` are sampled only at `cpu_cycle_end` in `RUN`, and at `t = CYCLE_LEN-1` in `DMA`/`INT`. Deassertion at other points has no effect on the current cycle.
- **Same-tick events:**
  - `cpu_cycle_end` with both requests high: go to `DMA`; the interrupt stays pending.
  - `r0_load` coinciding with `cpu_cycle_end` in `RUN`: the load takes effect, and the following DMA uses the loaded value.

## Structure
- Shared package `pixie_pkg` holds:
  - the state codes `SC_FETCH = 2'b00`, `SC_EXEC = 2'b01`, `SC_DMA = 2'b10` and `SC_INT = 2'b11`;
  - the FSM state enum;
  - the `CYCLE_LEN` default.
- One natural sub-module, `cdp1802_cycle_timer`, holds the tick counter `t`, its `clk_enable` qualification, and the last-tick flag.

## Test plan
- **Single DMA, address increment:** `r0` loaded to 16'h0100, mem[0100] = 8'hA5, `dma_req` high across one `cpu_cycle_end` then low → required:
  - exactly 8 ticks of `SC = 10` and `cpu_hold = 1`;
  - `mem_addr = 0100` at t0;
  - `data_out = A5` from t1;
  - `r0 = 0101` afterwards, then return to `RUN`.
- **Pixie line burst:** `dma_req` held for 8 cycles from R0 = 0x0200 → required: 64 contiguous `SC = 10` ticks, reads 0200..0207, final R0 = 0x0208.
- **Address wrap:** R0 = 0xFFFF, one DMA → required: read at FFFF, then R0 = 0x0000.
- **Priority and IE:**
  - `dma_req` and `int_req` both high, `ie = 1` → required: DMA cycles first, then one `INT` cycle with `SC = 11`, a one-tick `int_ack`, and `ie = 0`.
  - A second `int_req` is then ignored until `ie_set` is pulsed.
- **`clk_enable` gating:** `clk_enable` toggling at 1/3 duty during DMA → required: `SC = 10` persists for exactly 8 enabled ticks, and `mem_rd` spans exactly one enabled tick.
- **Reset mid-operation:** reset asserted at t = 4 of DMA with R0 = 0x0300 → required: all outputs immediately at reset values (R0 = 0, `ie = 1`, `SC = 00`), and a clean `RUN` state after release.

Source files
------------

// File: rtl/pixie_pkg.sv
// Shared definitions for the CDP1802 / CDP1861 Pixie DMA path.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package pixie_pkg;

    // CDP1802 state codes as seen on the SC pins
    localparam logic [1:0] SC_FETCH = 2'b00;
    localparam logic [1:0] SC_EXEC  = 2'b01;
    localparam logic [1:0] SC_DMA   = 2'b10;
    localparam logic [1:0] SC_INT   = 2'b11;

    // clk_enable ticks per CDP1802 machine cycle
    localparam int CYCLE_LEN_DEF = 8;

    typedef enum logic [1:0] {
        ST_RUN = 2'd0,
        ST_DMA = 2'd1,
        ST_INT = 2'd2
    } dma_state_e;

endpackage

// File: rtl/cdp1802_cycle_timer.sv
// Tick counter for one stolen machine cycle, advanced only on clk_enable.
// Latency: last_o is combinational from the registered count.
// Backpressure: none; clk_enable low freezes the count.
//
// Ports: clk, reset (async active-low), clk_enable, busy_i (a stolen cycle is
// in progress), t_o (tick index 0..CYCLE_LEN-1), last_o (final tick of cycle).
module cdp1802_cycle_timer #(
    parameter int CYCLE_LEN = 8,
    parameter int TW        = $clog2(CYCLE_LEN)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          clk_enable,
    input  logic          busy_i,
    output logic [TW-1:0] t_o,
    output logic          last_o
);

    logic [TW-1:0] t_q;
    logic [TW-1:0] t_d;

    assign last_o = busy_i && (t_q == TW'(CYCLE_LEN - 1));
    assign t_o    = t_q;

    // Count parks at 0 while the CPU owns the bus, so every stolen cycle,
    // including a back-to-back one, starts from t = 0.
    always_comb begin
        t_d = t_q;
        if (!busy_i || last_o) begin
            t_d = '0;
        end else begin
            t_d = t_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            t_q <= '0;
        end else if (clk_enable) begin
            t_q <= t_d;
        end
    end

endmodule

// File: rtl/cdp1802_dma_ctrl.sv
// Steals CDP1802 machine cycles for Pixie DMA-out (S2) and interrupt (S3).
// Latency: SC/cpu_hold/mem_rd change one tick after the cpu_cycle_end tick.
// Backpressure: holds the CPU via cpu_hold; clk_enable low freezes all state.
//
// Ports: clk/reset/clk_enable; CPU side cpu_sc, cpu_cycle_end, ie_set,
// r0_load/r0_in, cpu_hold; Pixie side dma_req, int_req, SC, data_out,
// int_ack; memory side mem_addr, mem_rd, mem_data; status r0, ie.
module cdp1802_dma_ctrl
    import pixie_pkg::*;
#(
    parameter int CYCLE_LEN = CYCLE_LEN_DEF,
    parameter int RD_LAT    = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        clk_enable,
    input  logic [1:0]  cpu_sc,
    input  logic        cpu_cycle_end,
    input  logic        dma_req,
    input  logic        int_req,
    input  logic        ie_set,
    input  logic        r0_load,
    input  logic [15:0] r0_in,
    input  logic [7:0]  mem_data,
    output logic [1:0]  SC,
    output logic [7:0]  data_out,
    output logic [15:0] mem_addr,
    output logic        mem_rd,
    output logic        cpu_hold,
    output logic        int_ack,
    output logic [15:0] r0,
    output logic        ie
);

    localparam int TW = $clog2(CYCLE_LEN);

    dma_state_e    state_q;
    logic [1:0]    sc_q;
    logic [7:0]    data_q;
    logic [15:0]   addr_q;
    logic          rd_q;
    logic          hold_q;
    logic          ack_q;
    logic [15:0]   r0_q;
    logic          ie_q;

    logic [TW-1:0] t;
    logic          last;
    logic          go_dma;
    logic          go_int;
    logic          go_run;
    logic [15:0]   dma_addr_d;

    cdp1802_cycle_timer #(
        .CYCLE_LEN (CYCLE_LEN),
        .TW        (TW)
    ) u_timer (
        .clk        (clk),
        .reset      (reset),
        .clk_enable (clk_enable),
        .busy_i     (state_q != ST_RUN),
        .t_o        (t),
        .last_o     (last)
    );

    // Decision points: cpu_cycle_end in RUN, last tick of a stolen cycle.
    // DMA always wins over INT; INT never chains directly into INT.
    always_comb begin
        go_dma     = 1'b0;
        go_int     = 1'b0;
        go_run     = 1'b0;
        dma_addr_d = r0_q;
        unique case (state_q)
            ST_RUN: begin
                go_dma = cpu_cycle_end && dma_req;
                go_int = cpu_cycle_end && !dma_req && int_req && ie_q;
                go_run = !go_dma && !go_int;
                // A load on the same tick feeds straight into the DMA address
                dma_addr_d = r0_load ? r0_in : r0_q;
            end
            ST_DMA: begin
                go_dma     = last && dma_req;
                go_int     = last && !dma_req && int_req && ie_q;
                go_run     = last && !go_dma && !go_int;
                dma_addr_d = r0_q + 16'd1;
            end
            ST_INT: begin
                go_dma = last && dma_req;
                go_run = last && !dma_req;
            end
            default: go_run = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_RUN;
            sc_q    <= SC_FETCH;
            data_q  <= 8'h00;
            addr_q  <= 16'h0000;
            rd_q    <= 1'b0;
            hold_q  <= 1'b0;
            ack_q   <= 1'b0;
            r0_q    <= 16'h0000;
            ie_q    <= 1'b1;
        end else if (clk_enable) begin
            // Strobes last exactly one enabled tick
            rd_q   <= 1'b0;
            addr_q <= 16'h0000;
            ack_q  <= 1'b0;

            if (state_q == ST_RUN) begin
                if (r0_load) r0_q <= r0_in;
                if (ie_set)  ie_q <= 1'b1;
            end

            // Entering t = RD_LAT: the read data is valid now
            if (state_q == ST_DMA && t == TW'(RD_LAT - 1)) begin
                data_q <= mem_data;
            end

            if (state_q == ST_DMA && last) begin
                r0_q <= r0_q + 16'd1;
            end

            if (go_dma) begin
                state_q <= ST_DMA;
                sc_q    <= SC_DMA;
                hold_q  <= 1'b1;
                rd_q    <= 1'b1;
                addr_q  <= dma_addr_d;
            end else if (go_int) begin
                state_q <= ST_INT;
                sc_q    <= SC_INT;
                hold_q  <= 1'b1;
                ack_q   <= 1'b1;
                ie_q    <= 1'b0;
            end else if (go_run) begin
                state_q <= ST_RUN;
                sc_q    <= cpu_sc;
                hold_q  <= 1'b0;
            end
        end
    end

    assign SC       = sc_q;
    assign data_out = data_q;
    assign mem_addr = addr_q;
    assign mem_rd   = rd_q;
    assign cpu_hold = hold_q;
    assign int_ack  = ack_q;
    assign r0       = r0_q;
    assign ie       = ie_q;

endmodule

// File: tb/tb_cdp1802_dma_ctrl.sv
// Self-checking bench for cdp1802_dma_ctrl against a schedule-queue model.
// Latency: outputs compared 1 ns after every clock edge.
// Backpressure: clk_enable gating exercised directed and at random.
module tb_cdp1802_dma_ctrl;

    localparam int CL = 8;
    localparam int RL = 1;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        clk_enable = 1'b1;
    logic [1:0]  cpu_sc = 2'b00;
    logic        cpu_cycle_end = 1'b0;
    logic        dma_req = 1'b0;
    logic        int_req = 1'b0;
    logic        ie_set = 1'b0;
    logic        r0_load = 1'b0;
    logic [15:0] r0_in = 16'h0000;
    logic [7:0]  mem_data;
    logic [1:0]  SC;
    logic [7:0]  data_out;
    logic [15:0] mem_addr;
    logic        mem_rd;
    logic        cpu_hold;
    logic        int_ack;
    logic [15:0] r0;
    logic        ie;

    logic [7:0]  mem [0:65535];
    assign mem_data = mem[mem_addr];

    always #5 clk = ~clk;

    cdp1802_dma_ctrl #(.CYCLE_LEN(CL), .RD_LAT(RL)) dut (
        .clk(clk), .reset(reset), .clk_enable(clk_enable),
        .cpu_sc(cpu_sc), .cpu_cycle_end(cpu_cycle_end),
        .dma_req(dma_req), .int_req(int_req), .ie_set(ie_set),
        .r0_load(r0_load), .r0_in(r0_in), .mem_data(mem_data),
        .SC(SC), .data_out(data_out), .mem_addr(mem_addr), .mem_rd(mem_rd),
        .cpu_hold(cpu_hold), .int_ack(int_ack), .r0(r0), .ie(ie)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Model: a queue of the stolen-cycle ticks still to be shown on the bus.
    // Empty queue means the CPU owns the bus.
    typedef struct {
        bit          is_int;
        int          idx;
        logic [15:0] addr;
    } slot_t;

    slot_t       sched[$];
    logic [15:0] r0_m;
    logic        ie_m;
    logic [7:0]  data_m;
    logic [1:0]  sc_run_m;

    task automatic model_reset();
        sched.delete();
        r0_m = 16'h0000; ie_m = 1'b1; data_m = 8'h00; sc_run_m = 2'b00;
    endtask

    task automatic plan(input bit is_int, input logic [15:0] addr);
        for (int k = 0; k < CL; k++) sched.push_back('{is_int, k, addr});
        if (is_int) ie_m = 1'b0;
    endtask

    task automatic model_edge();
        if (sched.size() > 0) begin
            slot_t f;
            f = sched.pop_front();
            if (!f.is_int && f.idx == RL - 1) data_m = mem[f.addr];
            if (f.idx == CL - 1) begin
                if (!f.is_int) r0_m = r0_m + 16'd1;
                if (dma_req) plan(1'b0, r0_m);
                else if (!f.is_int && int_req && ie_m) plan(1'b1, 16'h0);
                else sc_run_m = cpu_sc;
            end
        end else begin
            logic ie_old;
            ie_old = ie_m;
            if (r0_load) r0_m = r0_in;
            if (ie_set) ie_m = 1'b1;
            if (cpu_cycle_end && dma_req) plan(1'b0, r0_m);
            else if (cpu_cycle_end && int_req && ie_old) plan(1'b1, 16'h0);
            else sc_run_m = cpu_sc;
        end
    endtask

    task automatic compare_all();
        logic [1:0]  sc_e;
        logic        hold_e, rd_e, ack_e;
        logic [15:0] addr_e;
        sc_e = sc_run_m; hold_e = 0; rd_e = 0; ack_e = 0; addr_e = 0;
        if (sched.size() > 0) begin
            sc_e   = sched[0].is_int ? 2'b11 : 2'b10;
            hold_e = 1'b1;
            rd_e   = !sched[0].is_int && sched[0].idx == 0;
            ack_e  = sched[0].is_int && sched[0].idx == 0;
            addr_e = rd_e ? sched[0].addr : 16'h0;
        end
        chk("sc", SC, sc_e);
        chk("hold", cpu_hold, hold_e);
        chk("mem_rd", mem_rd, rd_e);
        chk("mem_addr", mem_addr, addr_e);
        chk("int_ack", int_ack, ack_e);
        chk("r0", r0, r0_m);
        chk("ie", ie, ie_m);
        chk("data_out", data_out, data_m);
    endtask

    task automatic step();
        @(posedge clk);
        if (!reset) model_reset();
        else if (clk_enable) model_edge();
        #1;
        compare_all();
    endtask

    task automatic load_r0(input logic [15:0] v);
        r0_load = 1'b1; r0_in = v; step(); r0_load = 1'b0;
    endtask

    task automatic cyc_end();
        cpu_cycle_end = 1'b1; step(); cpu_cycle_end = 1'b0;
    endtask

    int n_sc, n_rd, n_ack;

    initial begin
        for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
        mem[16'h0100] = 8'hA5;
        model_reset();

        // Reset state
        step(); step();
        chk("rst_sc", SC, 2'b00);
        chk("rst_ie", ie, 1'b1);
        chk("rst_r0", r0, 16'h0000);
        reset = 1'b1;
        cpu_sc = 2'b01;
        step(); step();

        // Single DMA with address increment
        load_r0(16'h0100);
        dma_req = 1'b1; cyc_end(); dma_req = 1'b0;
        n_sc = (SC == 2'b10) ? 1 : 0;
        chk("dma1_addr_t0", mem_addr, 16'h0100);
        step();
        chk("dma1_data_t1", data_out, 8'hA5);
        if (SC == 2'b10) n_sc++;
        for (int i = 0; i < 10; i++) begin step(); if (SC == 2'b10) n_sc++; end
        chk("dma1_len", n_sc, CL);
        chk("dma1_r0", r0, 16'h0101);
        chk("dma1_hold_after", cpu_hold, 1'b0);

        // Eight-cycle Pixie line burst
        load_r0(16'h0200);
        dma_req = 1'b1; cyc_end();
        n_sc = (SC == 2'b10) ? 1 : 0;
        for (int i = 1; i < 80; i++) begin
            dma_req = (i < 8 * CL - CL + 1);
            step();
            if (SC == 2'b10) n_sc++;
        end
        chk("burst_len", n_sc, 8 * CL);
        chk("burst_r0", r0, 16'h0208);

        // Address wrap
        load_r0(16'hFFFF);
        dma_req = 1'b1; cyc_end(); dma_req = 1'b0;
        chk("wrap_addr", mem_addr, 16'hFFFF);
        for (int i = 0; i < CL + 2; i++) step();
        chk("wrap_r0", r0, 16'h0000);

        // DMA before INT, then IE gating
        dma_req = 1'b1; int_req = 1'b1; cyc_end(); dma_req = 1'b0;
        n_ack = 0; n_sc = 0;
        for (int i = 0; i < 3 * CL; i++) begin
            step();
            if (int_ack) n_ack++;
            if (SC == 2'b11) n_sc++;
        end
        chk("prio_ack", n_ack, 1);
        chk("prio_int_len", n_sc, CL);
        chk("prio_ie", ie, 1'b0);
        cyc_end();
        n_sc = 0;
        for (int i = 0; i < CL; i++) begin step(); if (SC == 2'b11) n_sc++; end
        chk("ie_block", n_sc, 0);
        ie_set = 1'b1; step(); ie_set = 1'b0;
        chk("ie_set", ie, 1'b1);
        cyc_end();
        chk("ie_int_again", SC, 2'b11);
        int_req = 1'b0;
        for (int i = 0; i < CL + 2; i++) step();

        // clk_enable at 1/3 duty during a DMA cycle
        dma_req = 1'b1; cyc_end(); dma_req = 1'b0;
        n_sc = (SC == 2'b10) ? 1 : 0;
        n_rd = mem_rd ? 1 : 0;
        for (int i = 1; i < 40; i++) begin
            clk_enable = (i % 3 == 0);
            step();
            if (clk_enable && SC == 2'b10) n_sc++;
            if (clk_enable && mem_rd) n_rd++;
        end
        clk_enable = 1'b1;
        chk("gate_sc_len", n_sc, CL);
        chk("gate_rd_len", n_rd, 1);

        // Reset in the middle of a DMA cycle
        load_r0(16'h0300);
        dma_req = 1'b1; cyc_end(); dma_req = 1'b0;
        for (int i = 0; i < 4; i++) step();
        #2 reset = 1'b0;
        #1;
        model_reset();
        chk("mid_rst_sc", SC, 2'b00);
        chk("mid_rst_r0", r0, 16'h0000);
        chk("mid_rst_ie", ie, 1'b1);
        chk("mid_rst_hold", cpu_hold, 1'b0);
        chk("mid_rst_rd", mem_rd, 1'b0);
        step();
        reset = 1'b1;
        for (int i = 0; i < 4; i++) step();

        // Random traffic
        for (int i = 0; i < 4000; i++) begin
            clk_enable    = ($urandom_range(0, 3) != 0);
            cpu_sc        = 2'($urandom_range(0, 1));
            cpu_cycle_end = ($urandom_range(0, 5) == 0);
            if ($urandom_range(0, 9) == 0) dma_req = ~dma_req;
            if ($urandom_range(0, 14) == 0) int_req = ~int_req;
            ie_set        = !cpu_cycle_end && ($urandom_range(0, 39) == 0);
            r0_load       = ($urandom_range(0, 29) == 0);
            r0_in         = 16'($urandom);
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
